core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 130 +++++++++++++
 tb/tb_core_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle control sequencer for a single-issue core. It runs
//               fetch, execute, memory and commit over ready/valid buses, and
//               halts on ebreak or on a bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    input  logic        ifu_ready,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_ebreak,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_ready,
    input  logic        lsu_valid,
    output logic        pc_wen,
    output logic        reg_wen_gate,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] instret
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_IWAIT  = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_MEM    = 3'd4;
    localparam logic [2:0] c_MWAIT  = 3'd5;
    localparam logic [2:0] c_COMMIT = 3'd6;
    localparam logic [2:0] c_HALT   = 3'd7;

    localparam logic [31:0] c_NOP = 32'h0000_0013;
    localparam logic [31:0] c_TMO = 32'(MEM_TIMEOUT);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_tmo;
    logic [31:0] r_inst;
    logic [31:0] r_instret;
    logic        r_bus_err;
    logic        w_bus_phase;
    logic        w_handshake;
    logic        w_timeout;
    logic [31:0] w_tmo_cnt;

    always_comb begin
        w_bus_phase = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            c_FETCH: begin w_bus_phase = 1'b1; w_handshake = ifu_ready; end
            c_IWAIT: begin w_bus_phase = 1'b1; w_handshake = ifu_valid; end
            c_MEM:   begin w_bus_phase = 1'b1; w_handshake = lsu_ready; end
            c_MWAIT: begin w_bus_phase = 1'b1; w_handshake = lsu_valid; end
            default: begin w_bus_phase = 1'b0; w_handshake = 1'b0; end
        endcase
    end

    // w_tmo_cnt counts the current cycle, so the limit-th cycle of a phase is
    // the last one allowed; a handshake on that cycle still wins.
    assign w_tmo_cnt = r_tmo + 32'd1;
    assign w_timeout = w_bus_phase && !w_handshake && (w_tmo_cnt >= c_TMO);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   w_next = c_FETCH;
            c_FETCH:  if (w_timeout) w_next = c_HALT; else if (ifu_ready) w_next = c_IWAIT;
            c_IWAIT:  if (w_timeout) w_next = c_HALT; else if (ifu_valid) w_next = c_EXEC;
            c_EXEC: begin
                if (is_ebreak)                w_next = c_HALT;
                else if (is_load || is_store) w_next = c_MEM;
                else                          w_next = c_COMMIT;
            end
            c_MEM:    if (w_timeout) w_next = c_HALT; else if (lsu_ready) w_next = c_MWAIT;
            c_MWAIT:  if (w_timeout) w_next = c_HALT; else if (lsu_valid) w_next = c_COMMIT;
            c_COMMIT: w_next = c_FETCH;
            c_HALT:   w_next = c_HALT;
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_tmo     <= 32'd0;
            r_inst    <= c_NOP;
            r_instret <= 32'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            // Restart the budget on entry to a new bus transaction
            if ((w_next == c_FETCH || w_next == c_MEM) && (w_next != r_state)) begin
                r_tmo <= 32'd0;
            end else if (w_bus_phase) begin
                r_tmo <= w_tmo_cnt;
            end
            if (r_state == c_IWAIT && w_next == c_EXEC) begin
                r_inst <= ifu_rdata;
            end
            if (r_state == c_COMMIT) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign ifu_req      = (r_state == c_FETCH);
    assign lsu_req      = (r_state == c_MEM);
    assign lsu_wen      = (r_state == c_MEM) && is_store;
    assign pc_wen       = (r_state == c_COMMIT);
    assign reg_wen_gate = (r_state == c_COMMIT) && !is_store;
    assign halted       = (r_state == c_HALT);
    assign bus_err      = r_bus_err;
    assign inst         = r_inst;
    assign instret      = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Self-checking bench for core_sequencer with a bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

    localparam int TMO = 8;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_ALU    = 32'h0050_0093;
    localparam logic [31:0] c_LOAD   = 32'h0000_2083;
    localparam logic [31:0] c_STORE  = 32'h0010_2023;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, ifu_ready, ifu_valid;
    logic [31:0] ifu_rdata, inst;
    logic        is_load, is_store, is_ebreak;
    logic        lsu_req, lsu_wen, lsu_ready, lsu_valid;
    logic        pc_wen, reg_wen_gate, halted, bus_err;
    logic [31:0] instret;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] exp_instret;

    always #5 clk = ~clk;

    // Stand-in control unit decoding the instruction register
    assign is_load   = (inst[6:0] == 7'b0000011);
    assign is_store  = (inst[6:0] == 7'b0100011);
    assign is_ebreak = (inst == c_EBREAK);

    core_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_ready(ifu_ready), .ifu_valid(ifu_valid), .ifu_rdata(ifu_rdata),
        .inst(inst), .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_ready(lsu_ready), .lsu_valid(lsu_valid),
        .pc_wen(pc_wen), .reg_wen_gate(reg_wen_gate), .halted(halted), .bus_err(bus_err),
        .instret(instret)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifu_ready = 1'b0; ifu_valid = 1'b0; lsu_ready = 1'b0; lsu_valid = 1'b0;
        ifu_rdata = $urandom;
    endtask

    // Leaves the DUT in its first FETCH cycle with a fresh model
    task automatic do_reset;
        rst = 1'b1; idle_inputs();
        tick(); tick();
        rst = 1'b0;
        tick();
        exp_instret = 32'd0;
    endtask

    // One instruction from FETCH to the next FETCH (or HALT for ebreak).
    // rf/vf: idle cycles before ifu_ready/ifu_valid; rm/vm likewise for lsu.
    task automatic run_instr(input logic [31:0] word, input int rf, input int vf,
                             input int rm, input int vm);
        bit st, mem, eb;
        eb  = (word == c_EBREAK);
        st  = (word[6:0] == 7'b0100011);
        mem = st || (word[6:0] == 7'b0000011);
        for (int c = 0; c <= rf; c++) begin
            n_chk++;
            if (ifu_req !== 1'b1 || pc_wen !== 1'b0 || lsu_req !== 1'b0 || halted !== 1'b0) begin
                n_bad++;
                $display("FAIL fetch_phase: req=%b pc_wen=%b lsu_req=%b halted=%b want 1 0 0 0",
                         ifu_req, pc_wen, lsu_req, halted);
            end
            ifu_ready = (c == rf); ifu_valid = 1'b1; ifu_rdata = ~word;
            tick();
        end
        ifu_ready = 1'b0;
        for (int c = 0; c <= vf; c++) begin
            n_chk++;
            if (ifu_req !== 1'b0 || pc_wen !== 1'b0 || halted !== 1'b0) begin
                n_bad++;
                $display("FAIL iwait_phase: req=%b pc_wen=%b halted=%b want 0 0 0", ifu_req, pc_wen, halted);
            end
            ifu_valid = (c == vf); ifu_rdata = (c == vf) ? word : $urandom;
            tick();
        end
        ifu_valid = 1'b0;
        n_chk++;
        if (inst !== word || pc_wen !== 1'b0 || reg_wen_gate !== 1'b0 || lsu_req !== 1'b0) begin
            n_bad++;
            $display("FAIL exec: inst=%h pc_wen=%b rwg=%b lsu_req=%b want %h 0 0 0",
                     inst, pc_wen, reg_wen_gate, lsu_req, word);
        end
        tick();
        if (eb) begin
            n_chk++;
            if (halted !== 1'b1 || bus_err !== 1'b0 || pc_wen !== 1'b0 || ifu_req !== 1'b0 || instret !== exp_instret) begin
                n_bad++;
                $display("FAIL ebreak_halt: halted=%b bus_err=%b pc_wen=%b req=%b instret=%h want 1 0 0 0 %h",
                         halted, bus_err, pc_wen, ifu_req, instret, exp_instret);
            end
            return;
        end
        if (mem) begin
            for (int c = 0; c <= rm; c++) begin
                n_chk++;
                if (lsu_req !== 1'b1 || lsu_wen !== st || pc_wen !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mem_phase: lsu_req=%b lsu_wen=%b pc_wen=%b want 1 %b 0", lsu_req, lsu_wen, pc_wen, st);
                end
                lsu_ready = (c == rm); lsu_valid = 1'b1;
                tick();
            end
            lsu_ready = 1'b0;
            for (int c = 0; c <= vm; c++) begin
                n_chk++;
                if (lsu_req !== 1'b0 || pc_wen !== 1'b0 || halted !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mwait_phase: lsu_req=%b pc_wen=%b halted=%b want 0 0 0", lsu_req, pc_wen, halted);
                end
                lsu_valid = (c == vm);
                tick();
            end
            lsu_valid = 1'b0;
        end
        n_chk++;
        if (pc_wen !== 1'b1 || reg_wen_gate !== !st || inst !== word || lsu_req !== 1'b0) begin
            n_bad++;
            $display("FAIL commit: pc_wen=%b rwg=%b inst=%h lsu_req=%b want 1 %b %h 0",
                     pc_wen, reg_wen_gate, inst, lsu_req, !st, word);
        end
        tick();
        exp_instret = exp_instret + 32'd1;
        n_chk++;
        if (instret !== exp_instret || pc_wen !== 1'b0 || ifu_req !== 1'b1) begin
            n_bad++;
            $display("FAIL retire: instret=%h pc_wen=%b req=%b want %h 0 1", instret, pc_wen, ifu_req, exp_instret);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ifu_ready = 1'b1; ifu_valid = 1'b1; lsu_ready = 1'b1; lsu_valid = 1'b1;
        ifu_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        n_chk++;
        if (ifu_req !== 1'b0 || lsu_req !== 1'b0 || lsu_wen !== 1'b0 || pc_wen !== 1'b0 ||
            reg_wen_gate !== 1'b0 || halted !== 1'b0 || bus_err !== 1'b0 ||
            inst !== c_NOP || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values: req=%b lsu=%b wen=%b pc=%b rwg=%b h=%b be=%b inst=%h ir=%h want 0s inst=%h ir=0",
                     ifu_req, lsu_req, lsu_wen, pc_wen, reg_wen_gate, halted, bus_err, inst, instret, c_NOP);
        end
        rst = 1'b0; ifu_ready = 1'b0; lsu_ready = 1'b0;
        tick();
        exp_instret = 32'd0;
        // Stray valids in IDLE and FETCH must not load inst
        n_chk++;
        if (ifu_req !== 1'b1 || inst !== c_NOP) begin
            n_bad++;
            $display("FAIL idle_one_cycle: req=%b inst=%h want 1 %h", ifu_req, inst, c_NOP);
        end
        tick();
        n_chk++;
        if (ifu_req !== 1'b1 || inst !== c_NOP) begin
            n_bad++;
            $display("FAIL fetch_ignores_valid: req=%b inst=%h want 1 %h", ifu_req, inst, c_NOP);
        end
        idle_inputs();
        run_instr(c_ALU, 0, 0, 0, 0);
    endtask

    task automatic test_alu;
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(c_ALU, 0, 0, 0, 0);
    endtask

    task automatic test_load_store;
        do_reset();
        run_instr(c_LOAD, 0, 0, 3, 0);
        run_instr(c_STORE, 0, 0, 3, 0);
        run_instr(c_STORE, 1, 2, 0, 3);
    endtask

    task automatic test_random;
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(2, 0))
                0:       w = {$urandom_range(32'h01FF_FFFF, 0), 7'b0010011} & 32'hFFFF_FFFF;
                1:       w = {$urandom_range(32'h01FF_FFFF, 0), 7'b0000011} & 32'hFFFF_FFFF;
                default: w = {$urandom_range(32'h01FF_FFFF, 0), 7'b0100011} & 32'hFFFF_FFFF;
            endcase
            run_instr(w, $urandom_range(3, 0), $urandom_range(3, 0),
                      $urandom_range(3, 0), $urandom_range(3, 0));
        end
    endtask

    task automatic test_timeout_fetch;
        do_reset();
        for (int c = 1; c <= TMO; c++) begin
            n_chk++;
            if (halted !== 1'b0 || bus_err !== 1'b0 || ifu_req !== 1'b1) begin
                n_bad++;
                $display("FAIL fetch_wait_%0d: halted=%b bus_err=%b req=%b want 0 0 1", c, halted, bus_err, ifu_req);
            end
            tick();
        end
        ifu_ready = 1'b1; ifu_valid = 1'b1; ifu_rdata = c_ALU;
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if (halted !== 1'b1 || bus_err !== 1'b1 || ifu_req !== 1'b0 || pc_wen !== 1'b0 || instret !== 32'd0) begin
                n_bad++;
                $display("FAIL fetch_timeout: halted=%b bus_err=%b req=%b pc_wen=%b instret=%h want 1 1 0 0 0",
                         halted, bus_err, ifu_req, pc_wen, instret);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_timeout_boundary;
        do_reset();
        for (int c = 1; c < TMO; c++) tick();
        ifu_ready = 1'b1;
        tick();
        ifu_ready = 1'b0;
        n_chk++;
        if (halted !== 1'b0 || bus_err !== 1'b0 || ifu_req !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_on_last_cycle: halted=%b bus_err=%b req=%b want 0 0 0", halted, bus_err, ifu_req);
        end
        ifu_valid = 1'b1; ifu_rdata = c_ALU;
        tick();
        ifu_valid = 1'b0;
        tick();
        n_chk++;
        if (pc_wen !== 1'b1 || bus_err !== 1'b0) begin
            n_bad++;
            $display("FAIL boundary_commit: pc_wen=%b bus_err=%b want 1 0", pc_wen, bus_err);
        end
        tick();
        n_chk++;
        if (instret !== 32'd1) begin
            n_bad++;
            $display("FAIL boundary_instret: got %h want 1", instret);
        end
    endtask

    task automatic test_timeout_mem;
        do_reset();
        ifu_ready = 1'b1; tick();
        ifu_ready = 1'b0; ifu_valid = 1'b1; ifu_rdata = c_LOAD; tick();
        ifu_valid = 1'b0; tick();
        for (int c = 1; c <= TMO; c++) begin
            n_chk++;
            if (lsu_req !== 1'b1 || halted !== 1'b0) begin
                n_bad++;
                $display("FAIL mem_wait_%0d: lsu_req=%b halted=%b want 1 0", c, lsu_req, halted);
            end
            tick();
        end
        n_chk++;
        if (halted !== 1'b1 || bus_err !== 1'b1 || lsu_req !== 1'b0 || pc_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL mem_timeout: halted=%b bus_err=%b lsu_req=%b pc_wen=%b want 1 1 0 0",
                     halted, bus_err, lsu_req, pc_wen);
        end
    endtask

    task automatic test_ebreak;
        do_reset();
        run_instr(c_ALU, 0, 1, 0, 0);
        run_instr(c_EBREAK, 0, 0, 0, 0);
        ifu_ready = 1'b1; ifu_valid = 1'b1;
        tick(); tick();
        n_chk++;
        if (halted !== 1'b1 || bus_err !== 1'b0 || pc_wen !== 1'b0 || ifu_req !== 1'b0 || instret !== 32'd1) begin
            n_bad++;
            $display("FAIL halt_terminal: halted=%b bus_err=%b pc_wen=%b req=%b instret=%h want 1 0 0 0 1",
                     halted, bus_err, pc_wen, ifu_req, instret);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mwait;
        do_reset();
        ifu_ready = 1'b1; tick();
        ifu_ready = 1'b0; ifu_valid = 1'b1; ifu_rdata = c_LOAD; tick();
        ifu_valid = 1'b0; tick();
        lsu_ready = 1'b1; tick();
        lsu_ready = 1'b0;
        n_chk++;
        if (lsu_req !== 1'b0 || inst !== c_LOAD) begin
            n_bad++;
            $display("FAIL reach_mwait: lsu_req=%b inst=%h want 0 %h", lsu_req, inst, c_LOAD);
        end
        rst = 1'b1; tick();
        rst = 1'b0; lsu_valid = 1'b1; ifu_valid = 1'b1; ifu_rdata = c_STORE;
        n_chk++;
        if (pc_wen !== 1'b0 || reg_wen_gate !== 1'b0 || ifu_req !== 1'b0 || inst !== c_NOP || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_in_mwait: pc_wen=%b rwg=%b req=%b inst=%h instret=%h want 0 0 0 %h 0",
                     pc_wen, reg_wen_gate, ifu_req, inst, instret, c_NOP);
        end
        tick();
        n_chk++;
        if (ifu_req !== 1'b1 || pc_wen !== 1'b0 || instret !== 32'd0 || inst !== c_NOP) begin
            n_bad++;
            $display("FAIL after_reset_drop: req=%b pc_wen=%b instret=%h inst=%h want 1 0 0 %h",
                     ifu_req, pc_wen, instret, inst, c_NOP);
        end
        idle_inputs();
    endtask

    task automatic test_wrap;
        do_reset();
        force dut.r_instret = 32'hFFFF_FFFE;
        #1;
        release dut.r_instret;
        exp_instret = 32'hFFFF_FFFE;
        n_chk++;
        if (instret !== exp_instret) begin
            n_bad++;
            $display("FAIL preload: got %h want %h", instret, exp_instret);
        end
        run_instr(c_ALU, 0, 0, 0, 0);
        run_instr(c_LOAD, 1, 0, 0, 1);
        run_instr(c_ALU, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        exp_instret = 32'd0;
        test_reset();
        test_alu();
        test_load_store();
        test_random();
        test_timeout_fetch();
        test_timeout_boundary();
        test_timeout_mem();
        test_ebreak();
        test_reset_mwait();
        test_wrap();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
